// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM encoding, reset/halt
// constants and the wrapping next-PC adder.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_HALT_WAIT = 2'd2,
    ST_HALTED    = 2'd3
  } seq_state_t;

  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [3:0]  DEF_HLT_OPCODE = 4'hF;
  localparam logic [15:0] DEF_PC_INC     = 16'h0002;

  // 16-bit add with the carry dropped, so FFFE + 2 wraps to 0000.
  function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// 16-bit register with load enable and synchronous reset value.
module pc_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences single-outstanding instruction fetch against
// stalls, decode redirects and the HLT stop/commit protocol.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = DEF_HLT_OPCODE,
  parameter logic [15:0] PC_INC     = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_commit,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        flush_ifid,
  output logic        halted
);

  seq_state_t  state, next_state;
  logic [15:0] pc, pc_d, pc_inc, tgt, tgt_d, redir_aligned;
  logic        pc_en, tgt_en;
  logic        is_hlt;

  assign redir_aligned = {redirect_pc[15:1], 1'b0};
  assign pc_inc        = pc_add(pc, PC_INC);
  assign is_hlt        = (imem_rdata[15:12] == HLT_OPCODE);

  assign imem_addr   = pc;
  assign if_instr    = imem_rdata;
  assign if_pc_plus2 = pc_inc;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      tgt   <= 16'h0000;
    end else begin
      state <= next_state;
      if (tgt_en) tgt <= tgt_d;
    end
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    pc_d       = pc;
    tgt_en     = 1'b0;
    tgt_d      = tgt;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    flush_ifid = 1'b0;
    halted     = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if_valid = imem_valid & ~stall & ~redirect;
          if (redirect) begin
            flush_ifid = 1'b1;
            if (imem_valid) begin
              pc_en = 1'b1;
              pc_d  = redir_aligned;
            end else begin
              // Miss outstanding: the address must stay put until it returns.
              tgt_en     = 1'b1;
              tgt_d      = redir_aligned;
              next_state = ST_DRAIN;
            end
          end else if (imem_valid && !stall) begin
            if (is_hlt) next_state = ST_HALT_WAIT;
            else begin
              pc_en = 1'b1;
              pc_d  = pc_inc;
            end
          end
        end

        ST_DRAIN: begin
          imem_req = 1'b1;
          if (redirect) begin
            flush_ifid = 1'b1;
            tgt_en     = 1'b1;
            tgt_d      = redir_aligned;
          end
          if (imem_valid) begin
            pc_en      = 1'b1;
            pc_d       = redirect ? redir_aligned : tgt;
            next_state = ST_FETCH;
          end
        end

        ST_HALT_WAIT: begin
          if (redirect) begin
            flush_ifid = 1'b1;
            pc_en      = 1'b1;
            pc_d       = redir_aligned;
            next_state = ST_FETCH;
          end
        end

        ST_HALTED: begin
          halted = 1'b1;
        end

        default: next_state = ST_FETCH;
      endcase

      // A committed HLT outranks every in-flight PC update.
      if (halt_commit) begin
        next_state = ST_HALTED;
        pc_en      = 1'b0;
        tgt_en     = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt_commit, imem_valid;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid, flush_ifid, halted;
  logic [15:0] imem_addr, if_instr, if_pc_plus2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_commit (halt_commit),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .flush_ifid  (flush_ifid),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                       input logic hc, input logic v, input logic [15:0] data);
    rst = r; stall = st; redirect = rd; redirect_pc = rpc;
    halt_commit = hc; imem_valid = v; imem_rdata = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
    tick();
    drive(1, 0, 0, 16'h0, 0, 1, 16'h0);
    check("rst_req", imem_req, 0);
    check("rst_ifv", if_valid, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_halted", halted, 0);
    tick();
    check("rst_pc", imem_addr, 16'h0000);

    // Sequential hits.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, 0, 1, 16'h0000);
      check("seq_addr", imem_addr, 16'(i * 2));
      check("seq_ifv", if_valid, 1);
      check("seq_plus2", if_pc_plus2, 16'(i * 2 + 2));
      check("seq_req", imem_req, 1);
      tick();
    end

    // Stall for 3 cycles at 0006.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 16'h0, 0, 1, 16'h0000);
      check("stall_addr", imem_addr, 16'h0006);
      check("stall_ifv", if_valid, 0);
      tick();
    end
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0000);
    check("unstall_ifv", if_valid, 1);
    tick();
    check("unstall_addr", imem_addr, 16'h0008);

    for (int i = 0; i < 4; i++) tick();
    check("pre_miss_addr", imem_addr, 16'h0010);

    // Miss with a redirect arriving mid-miss.
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("miss1_req", imem_req, 1);
    check("miss1_ifv", if_valid, 0);
    tick();
    drive(0, 0, 1, 16'h0101, 0, 0, 16'h0);
    check("miss2_flush", flush_ifid, 1);
    check("miss2_addr", imem_addr, 16'h0010);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("miss3_addr", imem_addr, 16'h0010);
    check("miss3_flush", flush_ifid, 0);
    check("miss3_req", imem_req, 1);
    tick();
    check("miss4_addr", imem_addr, 16'h0010);
    tick();
    drive(0, 0, 0, 16'h0, 0, 1, 16'h1234);
    check("drain_ifv", if_valid, 0);
    check("drain_addr", imem_addr, 16'h0010);
    tick();
    check("post_drain_addr", imem_addr, 16'h0100);
    check("post_drain_req", imem_req, 1);

    // Redirect and stall together on a hit: redirect wins.
    drive(0, 1, 1, 16'h0020, 0, 1, 16'h0000);
    check("rs_flush", flush_ifid, 1);
    check("rs_ifv", if_valid, 0);
    tick();
    check("rs_addr", imem_addr, 16'h0020);

    // HLT fetched at 0020.
    drive(0, 0, 0, 16'h0, 0, 1, 16'hF000);
    check("hlt_ifv", if_valid, 1);
    check("hlt_instr", if_instr, 16'hF000);
    tick();
    drive(0, 1, 0, 16'h0, 0, 1, 16'h0000);
    check("hw_req", imem_req, 0);
    check("hw_ifv", if_valid, 0);
    check("hw_addr", imem_addr, 16'h0020);
    tick();
    check("hw_stall_addr", imem_addr, 16'h0020);
    drive(0, 0, 1, 16'h0040, 0, 0, 16'h0);
    check("hw_redir_flush", flush_ifid, 1);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("resume_addr", imem_addr, 16'h0040);
    check("resume_req", imem_req, 1);
    check("resume_halted", halted, 0);

    // Halt commit, then ignored redirect.
    drive(0, 0, 0, 16'h0, 1, 0, 16'h0);
    tick();
    drive(0, 0, 1, 16'h1234, 0, 1, 16'h0000);
    check("halted_set", halted, 1);
    check("halted_req", imem_req, 0);
    check("halted_flush", flush_ifid, 0);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("halted_sticky", halted, 1);
    check("halted_addr", imem_addr, 16'h0040);

    // Recover and exercise the wrap at FFFE (bit 0 of the target forced low).
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
    tick();
    drive(0, 0, 1, 16'hFFFF, 0, 1, 16'h0000);
    tick();
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0000);
    check("wrap_addr", imem_addr, 16'hFFFE);
    check("wrap_plus2", if_pc_plus2, 16'h0000);
    check("wrap_halted", halted, 0);
    tick();
    check("wrap_next", imem_addr, 16'h0000);
    tick();
    check("pre_drain_addr", imem_addr, 16'h0002);

    // Reset mid-miss while in DRAIN.
    drive(0, 0, 1, 16'h0300, 0, 0, 16'h0);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("drain2_addr", imem_addr, 16'h0002);
    drive(1, 0, 0, 16'h0, 0, 1, 16'h0000);
    check("rst_drain_req", imem_req, 0);
    check("rst_drain_ifv", if_valid, 0);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    check("after_rst_addr", imem_addr, 16'h0000);
    check("after_rst_req", imem_req, 1);
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0000);
    check("after_rst_ifv", if_valid, 1);
    tick();
    check("after_rst_next", imem_addr, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
